// File: rtl/note_frame_deserializer_if.sv
// Link bundle for the note-state deserializer.
//
// Carries the two serial link lines from the game board together with the
// rebuilt note vector and its status strobes.
//   note_serial_sync  sync line, high during bit 0 of each frame
//   note_serial_data  data line, one bit per bit period
//   active            last committed good frame, bit i = note slot i
//   frame_valid       1-cycle pulse when active is updated
//   frame_error       1-cycle pulse on a parity or framing error
//   error_count       saturating count of frame_error pulses
//
// master: the link side (drives the serial lines, observes the results)
// slave : the deserializer (samples the serial lines, drives the results)
interface note_frame_deserializer_if #(
    parameter int NUM_NOTES = 48
);
    logic                 note_serial_sync;
    logic                 note_serial_data;
    logic [NUM_NOTES-1:0] active;
    logic                 frame_valid;
    logic                 frame_error;
    logic [7:0]           error_count;

    modport master (
        output note_serial_sync,
        output note_serial_data,
        input  active,
        input  frame_valid,
        input  frame_error,
        input  error_count
    );

    modport slave (
        input  note_serial_sync,
        input  note_serial_data,
        output active,
        output frame_valid,
        output frame_error,
        output error_count
    );
endinterface

// File: rtl/note_frame_deserializer.sv
// Note-state link deserializer.
//
// Rebuilds the per-lane "note active" vector from the game board's serial
// link (one sync line, one data line, one bit per BIT_PERIOD clocks). Bits
// are sampled mid-period, every frame is checked for framing and parity
// errors, and only whole good frames are committed to active in one step.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   link   note_frame_deserializer_if.slave
//            note_serial_sync / note_serial_data : async serial inputs
//            active      : last committed good frame
//            frame_valid : 1-cycle pulse, one clock after the final sample tick
//            frame_error : 1-cycle pulse on parity or framing error
//            error_count : saturating count of frame_error pulses
module note_frame_deserializer #(
    parameter int NUM_NOTES     = 48,
    parameter int BIT_PERIOD    = 128,
    parameter int SAMPLE_OFFSET = 64,
    parameter int PARITY_EN     = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    note_frame_deserializer_if.slave    link
);

    localparam int PH_W  = $clog2(BIT_PERIOD);
    localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BIT_PERIOD - 1);
    localparam logic [PH_W-1:0]  PH_TICK  = PH_W'(SAMPLE_OFFSET);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NOTES - 1);

    typedef enum logic [1:0] {
        HUNT,
        RECEIVE,
        PARITY
    } state_t;

    // Two-flop synchronisers plus a delayed copy of sync for edge detection.
    logic sync_meta, sync_q, sync_prev;
    logic data_meta, data_q;
    logic sync_rise;

    logic [PH_W-1:0] phase;
    logic            tick;

    state_t               state, state_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [NUM_NOTES-1:0] shadow, shadow_next;
    logic [NUM_NOTES-1:0] active_q, active_next;
    logic                 valid_q, valid_next;
    logic                 error_q, error_next;
    logic [7:0]           err_cnt_q, err_cnt_next;

    // NOTE: sequential state is written only with non-blocking assignments,
    // so every flop samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            sync_prev <= 1'b0;
            data_meta <= 1'b0;
            data_q    <= 1'b0;
        end else begin
            sync_meta <= link.note_serial_sync;
            sync_q    <= sync_meta;
            sync_prev <= sync_q;
            data_meta <= link.note_serial_data;
            data_q    <= data_meta;
        end
    end

    assign sync_rise = sync_q & ~sync_prev;

    // Free-running bit-phase counter, pulled back to 0 by each sync rising
    // edge so the sample point tracks the sender's bit boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
        end else if (sync_rise || phase == PH_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + PH_W'(1);
        end
    end

    assign tick = (phase == PH_TICK);

    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        shadow_next  = shadow;
        active_next  = active_q;
        valid_next   = 1'b0;
        error_next   = 1'b0;

        if (tick) begin
            unique case (state)
                HUNT: begin
                    if (sync_q) begin
                        shadow_next    = '0;
                        shadow_next[0] = data_q;
                        idx_next       = IDX_W'(1);
                        state_next     = RECEIVE;
                    end
                end

                RECEIVE: begin
                    if (sync_q) begin
                        // Sync arrived early: drop the partial frame and
                        // treat this bit as bit 0 of a new one.
                        error_next     = 1'b1;
                        shadow_next    = '0;
                        shadow_next[0] = data_q;
                        idx_next       = IDX_W'(1);
                    end else begin
                        shadow_next[idx] = data_q;
                        if (idx == IDX_LAST) begin
                            idx_next = '0;
                            if (PARITY_EN != 0) begin
                                state_next = PARITY;
                            end else begin
                                active_next = shadow_next;
                                valid_next  = 1'b1;
                                state_next  = HUNT;
                            end
                        end else begin
                            idx_next = idx + IDX_W'(1);
                        end
                    end
                end

                PARITY: begin
                    if (sync_q) begin
                        error_next     = 1'b1;
                        shadow_next    = '0;
                        shadow_next[0] = data_q;
                        idx_next       = IDX_W'(1);
                        state_next     = RECEIVE;
                    end else begin
                        // Even parity: data bits plus parity bit XOR to 0.
                        if ((^shadow ^ data_q) == 1'b0) begin
                            active_next = shadow;
                            valid_next  = 1'b1;
                        end else begin
                            error_next = 1'b1;
                        end
                        idx_next   = '0;
                        state_next = HUNT;
                    end
                end

                default: begin
                    state_next = HUNT;
                end
            endcase
        end

        err_cnt_next = err_cnt_q;
        if (error_next && err_cnt_q != 8'hFF) begin
            err_cnt_next = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            idx       <= '0;
            shadow    <= '0;
            active_q  <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            shadow    <= shadow_next;
            active_q  <= active_next;
            valid_q   <= valid_next;
            error_q   <= error_next;
            err_cnt_q <= err_cnt_next;
        end
    end

    assign link.active      = active_q;
    assign link.frame_valid = valid_q;
    assign link.frame_error = error_q;
    assign link.error_count = err_cnt_q;

endmodule

// File: tb/tb_note_frame_deserializer.sv
// Self-checking bench for note_frame_deserializer.
//
// The sender is modelled bit by bit; each stimulus task predicts, at frame
// level, which pulses the link should produce and on which cycle, and
// pushes them onto an event queue that a negedge monitor consumes.
module tb_note_frame_deserializer;

    localparam int NN = 8;
    localparam int BP = 8;
    localparam int SO = 4;
    localparam int PE = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    note_frame_deserializer_if #(.NUM_NOTES(NN)) link ();

    note_frame_deserializer #(
        .NUM_NOTES    (NN),
        .BIT_PERIOD   (BP),
        .SAMPLE_OFFSET(SO),
        .PARITY_EN    (PE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .link (link)
    );

    typedef struct {
        bit          is_err;
        int          at;
        logic [NN-1:0] value;
    } ev_t;

    ev_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level model state.
    logic [NN-1:0] last_good = '0;
    int            exp_errs  = 0;
    int            err_seen  = 0;
    bit            pending_abort = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Monitor: every pulse must match the next predicted event exactly.
    always @(negedge clk) begin
        if (!reset) begin
            if (link.frame_valid || link.frame_error) begin
                check("valid_and_error", 64'(link.frame_valid & link.frame_error), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 64'({link.frame_valid, link.frame_error}), 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("pulse_kind", 64'(link.frame_error), 64'(e.is_err));
                    check("pulse_cycle", 64'(cyc), 64'(e.at));
                    if (e.is_err) begin
                        err_seen++;
                        check("error_count_at_pulse", 64'(link.error_count),
                              64'((err_seen > 255) ? 255 : err_seen));
                    end else begin
                        check("active_at_valid", 64'(link.active), 64'(e.value));
                    end
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].at) begin
                ev_t e;
                e = exp_q.pop_front();
                check("missed_pulse_due_at", 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic push_ev(input bit is_err, input int at, input logic [NN-1:0] value);
        ev_t e;
        e.is_err = is_err;
        e.at     = at;
        e.value  = value;
        exp_q.push_back(e);
        if (is_err) begin
            exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
        end else begin
            last_good = value;
        end
    endtask

    // Called at a negedge; holds the bit for one bit period.
    task automatic send_bit(input logic s, input logic d);
        link.note_serial_sync = s;
        link.note_serial_data = d;
        repeat (BP) @(negedge clk);
    endtask

    task automatic send_idle(input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(1'b0, 1'($urandom));
    endtask

    // hold: number of extra leading bit periods with sync high before the
    // real bit 0; each of them after the first sync bit restarts the frame.
    task automatic send_frame(input logic [NN-1:0] value, input bit good, input int hold);
        int   c;
        logic par;
        c = cyc;
        if (pending_abort) push_ev(1'b1, c + BP, '0);
        pending_abort = 1'b0;
        for (int j = 1; j <= hold; j++) push_ev(1'b1, c + (j + 1) * BP, '0);
        push_ev(!good, c + (hold + NN + 1) * BP, value);
        for (int j = 0; j < hold; j++) send_bit(1'b1, 1'($urandom));
        par = ^value;
        if (!good) par = ~par;
        for (int i = 0; i < NN; i++) send_bit(i == 0, value[i]);
        send_bit(1'b0, par);
    endtask

    // Sends only the first k bits of a frame; must be followed by send_frame.
    task automatic send_partial(input logic [NN-1:0] value, input int k);
        for (int i = 0; i < k; i++) send_bit(i == 0, value[i]);
        pending_abort = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        link.note_serial_sync = 1'b0;
        link.note_serial_data = 1'b0;
        exp_q.delete();
        pending_abort = 1'b0;
        last_good = '0;
        exp_errs  = 0;
        err_seen  = 0;
        repeat (3) @(negedge clk);
        check("reset_active", 64'(link.active), 0);
        check("reset_valid", 64'(link.frame_valid), 0);
        check("reset_error", 64'(link.frame_error), 0);
        check("reset_error_count", 64'(link.error_count), 0);
        reset = 1'b0;
        // Start the sender 5 clocks after the last reset edge so its bit
        // edges sit a fixed distance from the receiver's sample point.
        repeat (5) @(negedge clk);
    endtask

    task automatic checkpoint(input string tag);
        for (int i = 0; i < 4 * BP && exp_q.size() != 0; i++) @(negedge clk);
        check({tag, "_drained"}, 64'(exp_q.size()), 0);
        check({tag, "_active"}, 64'(link.active), 64'(last_good));
        check({tag, "_error_count"}, 64'(link.error_count), 64'(exp_errs));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        link.note_serial_sync = 1'b0;
        link.note_serial_data = 1'b0;
        @(negedge clk);
        do_reset();

        // 1: good frame 0xA5 (parity 0).
        send_frame(8'hA5, 1'b1, 0);
        send_idle(2);
        checkpoint("t1");

        // 2: bad parity, active holds.
        send_frame(8'h3C, 1'b0, 0);
        send_idle(1);
        checkpoint("t2");

        // 3: sync re-raised at bit 5, then a full frame 0x0F.
        send_partial(8'h55, 5);
        send_frame(8'h0F, 1'b1, 0);
        send_idle(1);
        checkpoint("t3");

        // 4: back-to-back frames; pulse spacing comes from predicted cycles.
        send_frame(8'h01, 1'b1, 0);
        send_frame(8'h02, 1'b1, 0);
        send_frame(8'h04, 1'b1, 0);
        send_idle(1);
        checkpoint("t4");

        // Sync held high for several bits: each extra sync bit is an error.
        send_frame(8'hC3, 1'b1, 2);
        send_idle(1);
        checkpoint("hold");

        // 5: reset mid-frame at bit 4, then 0xFF commits normally.
        send_partial(8'h9A, 4);
        do_reset();
        check("t5_active_after_reset", 64'(link.active), 0);
        send_frame(8'hFF, 1'b1, 0);
        send_idle(1);
        checkpoint("t5");

        // Randomized mix of frame types and gaps.
        for (int n = 0; n < 40; n++) begin
            logic [NN-1:0] v;
            int kind;
            v = NN'($urandom);
            kind = $urandom_range(0, 5);
            case (kind)
                3:       send_frame(v, 1'b0, 0);
                4: begin
                    send_partial(NN'($urandom), $urandom_range(1, NN));
                    send_frame(v, 1'b1, 0);
                end
                5:       send_frame(v, 1'b1, $urandom_range(1, 2));
                default: send_frame(v, 1'b1, 0);
            endcase
            send_idle($urandom_range(0, 2));
        end
        checkpoint("random");

        // 6: 260 bad-parity frames saturate the error counter.
        for (int n = 0; n < 260; n++) send_frame(NN'($urandom), 1'b0, 0);
        send_idle(1);
        checkpoint("t6_saturate");

        // Sender phase skewed by 3 clocks; realignment on sync recovers.
        repeat (3) @(negedge clk);
        send_frame(8'h6B, 1'b1, 0);
        send_frame(8'h94, 1'b1, 0);
        send_idle(1);
        checkpoint("t6_skew");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
